// File: rtl/up_dn_counter_pkg.sv
// up_dn_counter_pkg: default counter width and derived saturation limit shared by the counter and its users.
package up_dn_counter_pkg;
  localparam int unsigned UDC_WIDTH = 5;
  localparam int unsigned UDC_MAX = 2**UDC_WIDTH - 1;
endpackage

// File: rtl/up_dn_counter.sv
// up_dn_counter: loadable saturating up/down counter with combinational High/Low limit flags.
module up_dn_counter
  import up_dn_counter_pkg::*;
#(
  parameter int unsigned WIDTH = UDC_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] In,
  input  logic             Load,
  input  logic             Up,
  input  logic             Down,
  output logic [WIDTH-1:0] Counter_Reg,
  output logic             High,
  output logic             Low
);
  assign High = &Counter_Reg;
  assign Low = ~|Counter_Reg;
  // Down takes priority even when saturated at zero, so it also blocks Up there.
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) Counter_Reg <= '0;
    else if (Load) Counter_Reg <= In;
    else if (Down) Counter_Reg <= Low ? Counter_Reg : Counter_Reg - WIDTH'(1);
    else if (Up) Counter_Reg <= High ? Counter_Reg : Counter_Reg + WIDTH'(1);
endmodule

// File: tb/tb_up_dn_counter.sv
// tb_up_dn_counter: directed plus randomized checks of up_dn_counter against an integer reference model.
module tb_up_dn_counter;
  import up_dn_counter_pkg::*;
  localparam int W = UDC_WIDTH;
  localparam int MAXV = UDC_MAX;
  logic Clk = 0, Rst_n = 0, Load = 0, Up = 0, Down = 0;
  logic [W-1:0] In = '0;
  logic [W-1:0] Counter_Reg;
  logic High, Low;
  int compared = 0, mismatched = 0;
  int m = 0;
  bit cmp_en = 0;
  up_dn_counter #(.WIDTH(W)) dut (.Clk(Clk), .Rst_n(Rst_n), .In(In), .Load(Load), .Up(Up), .Down(Down),
    .Counter_Reg(Counter_Reg), .High(High), .Low(Low));
  always #5 Clk = ~Clk;
  // reference: plain integer arithmetic with clamping at the limits
  always @(posedge Clk or negedge Rst_n)
    if (!Rst_n) m = 0;
    else if (Load) m = int'(In);
    else if (Down) m = (m > 0) ? m - 1 : m;
    else if (Up) m = (m < MAXV) ? m + 1 : m;
  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge Clk)
    if (cmp_en) begin
      chk("model_count", int'(Counter_Reg), m);
      chk("model_high", int'(High), int'(m == MAXV));
      chk("model_low", int'(Low), int'(m == 0));
    end
  task automatic cyc(input bit ld, input int din, input bit up, input bit dn);
    Load = ld; In = W'(din); Up = up; Down = dn;
    @(posedge Clk);
    #1;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "timeout");
  end
  initial begin
    #12;
    chk("reset_count", int'(Counter_Reg), 0);
    chk("reset_low", int'(Low), 1);
    chk("reset_high", int'(High), 0);
    @(negedge Clk);
    Rst_n = 1;
    cmp_en = 1;
    @(posedge Clk); #1;
    cyc(1, 15, 0, 0);
    chk("load15", int'(Counter_Reg), 15);
    cyc(1, 14, 0, 0);
    cyc(1, 15, 1, 1);
    chk("load_wins", int'(Counter_Reg), 15);
    cyc(0, 0, 1, 1);
    chk("down_over_up", int'(Counter_Reg), 14);
    cyc(1, 15, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 1, 1);
      if (i == 14) chk("down_reach0", int'(Counter_Reg), 0);
    end
    chk("down_sat", int'(Counter_Reg), 0);
    chk("down_sat_low", int'(Low), 1);
    cyc(0, 0, 1, 0);
    chk("up_first", int'(Counter_Reg), 1);
    for (int i = 0; i < 30; i++) cyc(0, 0, 1, 0);
    chk("up_reach31", int'(Counter_Reg), 31);
    chk("up_high", int'(High), 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);
    chk("up_sat", int'(Counter_Reg), 31);
    cyc(0, 0, 0, 1);
    chk("down_from_max", int'(Counter_Reg), 30);
    chk("down_from_max_high", int'(High), 0);
    cyc(1, 7, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
    chk("idle_count", int'(Counter_Reg), 7);
    chk("idle_high", int'(High), 0);
    chk("idle_low", int'(Low), 0);
    cyc(1, 12, 1, 0);
    #2 Rst_n = 0;
    #1;
    chk("async_rst_count", int'(Counter_Reg), 0);
    chk("async_rst_low", int'(Low), 1);
    chk("async_rst_high", int'(High), 0);
    @(negedge Clk);
    Rst_n = 1;
    @(posedge Clk); #1;
    for (int i = 0; i < 3000; i++) begin
      int r, d;
      r = int'($urandom_range(0, 3));
      d = (r == 0) ? 0 : (r == 1) ? MAXV : int'($urandom_range(0, MAXV));
      cyc($urandom_range(0, 15) == 0, d, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #1 Rst_n = 0;
        #1 Rst_n = 1;
      end
    end
    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
